// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg -- shared RV32I decode definitions.
//   RV_XLEN          : datapath / PC width (only 32 is supported)
//   OPC_*            : RV32I base opcodes recognised by the decode stage
//   imm_fmt_e        : immediate format selected by opcode
//   decode_bundle_t  : registered operand bundle handed to the ALU
//   imm_fmt_of()     : opcode -> immediate format
//   opcode_is_legal(): opcode belongs to the supported RV32I set
// -----------------------------------------------------------------------------
package rv_pkg;

  localparam int unsigned RV_XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // IMM_NONE covers R-type and illegal opcodes: both must present imm = 0.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [RV_XLEN-1:0] rs1_value;
    logic [RV_XLEN-1:0] rs2_value;
    logic [RV_XLEN-1:0] imm_value;
    logic [RV_XLEN-1:0] pc;
    logic [4:0]         rd;
    logic               illegal;
  } decode_bundle_t;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_e fmt;
    fmt = IMM_NONE;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  function automatic logic opcode_is_legal(input logic [6:0] opcode);
    logic legal;
    legal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// -----------------------------------------------------------------------------
// rv_regfile -- integer register file, 2 async read ports, 1 sync write port.
//   clk, rst_n          : clock, asynchronous active-low reset (clears all regs)
//   raddr1/raddr2       : read indices; index 0 always returns zero
//   rdata1/rdata2       : combinational read data
//   we, waddr, wdata    : write port, committed on the rising edge; waddr 0 ignored
// -----------------------------------------------------------------------------
module rv_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // x0 is forced on the read side, so regs_q[0] never needs a write guard.
  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/rv_decode_stage.sv
// -----------------------------------------------------------------------------
// rv_decode_stage -- RV32I decode / operand-fetch stage feeding the ALU.
//   Splits the instruction fields, builds the immediate, reads rs1/rs2 and
//   registers one operand bundle per accepted instruction.
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready           : fetch handshake for inst_in/pc_in
//   inst_in, pc_in              : instruction word and its PC
//   flush                       : drop held bundle and any same-cycle accept
//   out_valid/out_ready         : ALU handshake for the operand bundle
//   opcode_out .. illegal_out   : registered operand bundle
//   wb_en, wb_rd, wb_data       : writeback into the register file
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The sender holds its payload stable while valid & !ready. Here
// in_ready = !out_valid | out_ready, so a bundle held for a stalled ALU
// blocks new accepts and never changes until it is consumed.
//
// Configuration
//   RV_DECODE_WB_BYPASS_EN : when defined, a writeback to rs1/rs2 in the
//   accepting cycle is forwarded into the captured operand (write-before-
//   read). Undefined (default): the old register value is captured.
// -----------------------------------------------------------------------------
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int unsigned      XLEN   = 32,
  parameter int unsigned      NREGS  = 32,
  parameter logic [XLEN-1:0]  RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out,
  output logic [XLEN-1:0] rs1_value_out,
  output logic [XLEN-1:0] rs2_value_out,
  output logic [XLEN-1:0] imm_value_out,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd_out,
  output logic            illegal_out,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  // ---------------------------------------------------------------------------
  // Field split
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic       legal;
  imm_fmt_e   imm_fmt;

  assign opcode  = inst_in[6:0];
  assign rs1_idx = inst_in[19:15];
  assign rs2_idx = inst_in[24:20];
  assign legal   = opcode_is_legal(opcode);
  assign imm_fmt = imm_fmt_of(opcode);

  // ---------------------------------------------------------------------------
  // Register file and operand selection
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  rv_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (5)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

`ifdef RV_DECODE_WB_BYPASS_EN
  // Same-cycle writeback wins over the stored value; x0 is never forwarded.
  assign rs1_fwd = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1_idx)) ? wb_data : rf_rdata1;
  assign rs2_fwd = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2_idx)) ? wb_data : rf_rdata2;
`else
  assign rs1_fwd = rf_rdata1;
  assign rs2_fwd = rf_rdata2;
`endif

  // ---------------------------------------------------------------------------
  // Immediate generator
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] imm_d;

  always_comb begin
    imm_d = '0;
    unique case (imm_fmt)
      IMM_I: imm_d = {{20{inst_in[31]}}, inst_in[31:20]};
      IMM_S: imm_d = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
      IMM_B: imm_d = {{19{inst_in[31]}}, inst_in[31], inst_in[7],
                      inst_in[30:25], inst_in[11:8], 1'b0};
      IMM_U: imm_d = {inst_in[31:12], 12'b0};
      IMM_J: imm_d = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12],
                      inst_in[20], inst_in[30:21], 1'b0};
      default: imm_d = '0;  // R-type must present zero: the ALU reads imm[11:5]
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bundle build and handshake register
  // ---------------------------------------------------------------------------
  decode_bundle_t bundle_d;
  decode_bundle_t bundle_q;
  logic           out_valid_d;
  logic           out_valid_q;
  logic           accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    bundle_d           = '0;
    bundle_d.opcode    = opcode;
    bundle_d.funct3    = inst_in[14:12];
    bundle_d.funct7    = (opcode == OPC_OP) ? inst_in[31:25] : 7'd0;
    bundle_d.rs1_value = legal ? rs1_fwd : '0;
    bundle_d.rs2_value = legal ? rs2_fwd : '0;
    bundle_d.imm_value = imm_d;
    bundle_d.pc        = pc_in;
    bundle_d.rd        = inst_in[11:7];
    bundle_d.illegal   = !legal;
  end

  // Flush overrides a same-cycle accept; otherwise a consumed bundle clears.
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      bundle_q.pc <= RST_PC;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept && !flush) begin
        bundle_q <= bundle_d;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign opcode_out    = bundle_q.opcode;
  assign funct3_out    = bundle_q.funct3;
  assign funct7_out    = bundle_q.funct7;
  assign rs1_value_out = bundle_q.rs1_value;
  assign rs2_value_out = bundle_q.rs2_value;
  assign imm_value_out = bundle_q.imm_value;
  assign pc_out        = bundle_q.pc;
  assign rd_out        = bundle_q.rd;
  assign illegal_out   = bundle_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_rv_decode_stage -- bench for rv_decode_stage: directed scenarios with
// literal expectations followed by randomized traffic checked every cycle
// against a behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_rv_decode_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst_in = '0;
  logic [31:0] pc_in = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [6:0]  opcode_out;
  logic [2:0]  funct3_out;
  logic [6:0]  funct7_out;
  logic [31:0] rs1_value_out;
  logic [31:0] rs2_value_out;
  logic [31:0] imm_value_out;
  logic [31:0] pc_out;
  logic [4:0]  rd_out;
  logic        illegal_out;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;

  rv_decode_stage #(
    .XLEN   (32),
    .NREGS  (32),
    .RST_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .inst_in       (inst_in),
    .pc_in         (pc_in),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .opcode_out    (opcode_out),
    .funct3_out    (funct3_out),
    .funct7_out    (funct7_out),
    .rs1_value_out (rs1_value_out),
    .rs2_value_out (rs2_value_out),
    .imm_value_out (imm_value_out),
    .pc_out        (pc_out),
    .rd_out        (rd_out),
    .illegal_out   (illegal_out),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data)
  );

  // ---------------------------------------------------------------------------
  // Counters and check helper
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        illegal;
  } exp_t;

  logic [31:0] m_regs [32];
  logic        m_valid;
  exp_t        m_b;

  function automatic exp_t model_decode(input logic [31:0] inst, input logic [31:0] pc,
                                        input logic [31:0] v1, input logic [31:0] v2);
    exp_t        e;
    logic [6:0]  op;
    logic        legal;
    logic [11:0] i12;
    logic [11:0] s12;
    logic [12:0] b13;
    logic [20:0] j21;
    op  = inst[6:0];
    i12 = inst[31:20];
    s12 = {inst[31:25], inst[11:7]};
    b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    legal = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h23) ||
            (op == 7'h63) || (op == 7'h37) || (op == 7'h17) || (op == 7'h6F) ||
            (op == 7'h67);
    e.opcode  = op;
    e.funct3  = inst[14:12];
    e.funct7  = (op == 7'h33) ? inst[31:25] : 7'd0;
    e.rs1     = legal ? v1 : 32'd0;
    e.rs2     = legal ? v2 : 32'd0;
    e.pc      = pc;
    e.rd      = inst[11:7];
    e.illegal = !legal;
    case (op)
      7'h13, 7'h03, 7'h67: e.imm = 32'($signed(i12));
      7'h23:               e.imm = 32'($signed(s12));
      7'h63:               e.imm = 32'($signed(b13));
      7'h37, 7'h17:        e.imm = inst & 32'hFFFF_F000;
      7'h6F:               e.imm = 32'($signed(j21));
      default:             e.imm = 32'd0;
    endcase
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] v1;
    logic [31:0] v2;
    if (!rst_n) begin
      m_valid = 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else begin
      a1 = inst_in[19:15];
      a2 = inst_in[24:20];
      v1 = m_regs[a1];
      v2 = m_regs[a2];
`ifdef RV_DECODE_WB_BYPASS_EN
      if (wb_en && wb_rd != 0 && wb_rd == a1) v1 = wb_data;
      if (wb_en && wb_rd != 0 && wb_rd == a2) v2 = wb_data;
`endif
      if (flush) begin
        m_valid = 1'b0;
      end else if (in_valid && (!m_valid || out_ready)) begin
        m_b     = model_decode(inst_in, pc_in, v1, v2);
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
    end
  end

  // Every-cycle comparison, sampled after the DUT and model have settled.
  always @(posedge clk) begin
    #2;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("opcode", 32'(opcode_out), 32'(m_b.opcode));
      chk("funct3", 32'(funct3_out), 32'(m_b.funct3));
      chk("funct7", 32'(funct7_out), 32'(m_b.funct7));
      chk("rs1_value", rs1_value_out, m_b.rs1);
      chk("rs2_value", rs2_value_out, m_b.rs2);
      chk("imm_value", imm_value_out, m_b.imm);
      chk("pc", pc_out, m_b.pc);
      chk("rd", 32'(rd_out), 32'(m_b.rd));
      chk("illegal", 32'(illegal_out), 32'(m_b.illegal));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all input changes on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    wb_en    = 1'b0;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    @(negedge clk);
    idle();
    in_valid = 1'b1;
    inst_in  = inst;
    pc_in    = pc;
    @(negedge clk);
    idle();
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [31:0] data);
    @(negedge clk);
    idle();
    wb_en   = 1'b1;
    wb_rd   = rd;
    wb_data = data;
    @(negedge clk);
    idle();
  endtask

  task automatic random_cycle(inout logic [31:0] pc);
    logic [31:0] inst;
    logic [6:0]  op;
    @(negedge clk);
    inst = $urandom();
    case ($urandom_range(0, 9))
      0: op = 7'h33;
      1: op = 7'h13;
      2: op = 7'h03;
      3: op = 7'h23;
      4: op = 7'h63;
      5: op = 7'h37;
      6: op = 7'h17;
      7: op = 7'h6F;
      8: op = 7'h67;
      default: op = 7'($urandom_range(0, 127));
    endcase
    inst[6:0] = op;
    if ((op == 7'h33 || op == 7'h13) && $urandom_range(0, 1) == 1)
      inst[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    in_valid  = ($urandom_range(0, 3) != 0);
    out_ready = ($urandom_range(0, 3) != 0);
    flush     = ($urandom_range(0, 15) == 0);
    inst_in   = inst;
    pc_in     = pc;
    pc        = pc + 32'd4;
    wb_en     = ($urandom_range(0, 1) == 1);
    wb_rd     = ($urandom_range(0, 3) == 0) ? inst[19:15] : 5'($urandom_range(0, 31));
    wb_data   = $urandom();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rpc;
    logic [31:0] exp_bypass;

    repeat (3) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset pc_out", pc_out, RST_PC);
    chk("reset imm", imm_value_out, 32'd0);
    rst_n = 1'b1;

    // sub x2,x3,x3 after x3 = 0x10
    write_reg(5'd3, 32'h0000_0010);
    send(32'h4031_8133, 32'h0000_1000);
    chk("sub valid", 32'(out_valid), 32'd1);
    chk("sub funct7", 32'(funct7_out), 32'h20);
    chk("sub rs1", rs1_value_out, 32'h10);
    chk("sub rs2", rs2_value_out, 32'h10);
    chk("sub imm", imm_value_out, 32'd0);
    chk("sub rd", 32'(rd_out), 32'd2);

    // addi x1,x3,-1
    send(32'hFFF1_8093, 32'h0000_1004);
    chk("addi imm", imm_value_out, 32'hFFFF_FFFF);
    chk("addi opcode", 32'(opcode_out), 32'h13);
    chk("addi rd", 32'(rd_out), 32'd1);
    chk("addi rs1", rs1_value_out, 32'h10);

    // Stall: ALU not ready for two cycles while fetch offers addi x4,x0,5
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst_in   = 32'h0050_0213;
    pc_in     = 32'h0000_1008;
    #1;
    chk("stall in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("stall in_ready held", 32'(in_ready), 32'd0);
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall pc", pc_out, 32'h0000_1004);
      chk("stall imm", imm_value_out, 32'hFFFF_FFFF);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain pc", pc_out, 32'h0000_1008);
    chk("drain imm", imm_value_out, 32'd5);
    @(negedge clk);
    chk("drain empty", 32'(out_valid), 32'd0);

    // flush with same-cycle accept, write to x0 ignored
    in_valid = 1'b1;
    inst_in  = 32'h0050_0213;
    pc_in    = 32'h0000_2000;
    flush    = 1'b1;
    wb_en    = 1'b1;
    wb_rd    = 5'd0;
    wb_data  = 32'h0000_DEAD;
    @(negedge clk);
    idle();
    chk("flush out_valid", 32'(out_valid), 32'd0);
    send(32'h0000_04B3, 32'h0000_2004);  // add x9,x0,x0
    chk("x0 rs1", rs1_value_out, 32'd0);
    chk("x0 rs2", rs2_value_out, 32'd0);

    // writeback to x7 in the cycle addi x10,x7,0 is accepted
`ifdef RV_DECODE_WB_BYPASS_EN
    exp_bypass = 32'hA5A5_A5A5;
`else
    exp_bypass = 32'd0;
`endif
    @(negedge clk);
    wb_en    = 1'b1;
    wb_rd    = 5'd7;
    wb_data  = 32'hA5A5_A5A5;
    in_valid = 1'b1;
    inst_in  = 32'h0003_8513;
    pc_in    = 32'h0000_3000;
    @(negedge clk);
    idle();
    chk("wb same-cycle rs1", rs1_value_out, exp_bypass);
    chk("wb same-cycle rd", 32'(rd_out), 32'd10);
    send(32'h0003_8633, 32'h0000_3004);  // add x12,x7,x0
    chk("x7 written", rs1_value_out, 32'hA5A5_A5A5);

    // illegal opcode 0x7F reading x7: operands and imm forced to zero
    send(32'h4073_80FF, 32'h0000_3008);
    chk("illegal flag", 32'(illegal_out), 32'd1);
    chk("illegal rs1", rs1_value_out, 32'd0);
    chk("illegal rs2", rs2_value_out, 32'd0);
    chk("illegal imm", imm_value_out, 32'd0);
    chk("illegal funct7", 32'(funct7_out), 32'd0);

    // reset while a bundle is held
    write_reg(5'd5, 32'h0000_0055);
    send(32'h0002_85B3, 32'h0000_4000);  // add x11,x5,x0
    out_ready = 1'b0;
    chk("pre-reset valid", 32'(out_valid), 32'd1);
    chk("pre-reset rs1", rs1_value_out, 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset valid", 32'(out_valid), 32'd0);
    chk("async reset pc", pc_out, RST_PC);
    chk("async reset rs1", rs1_value_out, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(32'h0002_85B3, 32'h0000_5000);
    chk("x5 after reset", rs1_value_out, 32'd0);

    // randomized traffic
    rpc = 32'h0001_0000;
    for (int n = 0; n < 3000; n++) begin
      random_cycle(rpc);
    end
    @(negedge clk);
    idle();
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
